// File: rtl/spinn_aer_out_mapper.sv
// spinn_aer_out_mapper
//   SpiNNaker-packet to AER-event mapper for the SpiNNaker-link output path.
//   Accepts 72-bit packets and classifies each consumed packet as follows:
//     - Non-multicast packets are dropped.
//     - Packets that fail odd parity are dropped and flagged.
//     - Packets whose key does not match the key filter are dropped.
//     - All remaining packets are buffered in a ring FIFO.
//   Buffered keys are emitted as AER words under a valid/ready handshake.
//   The module keeps saturating drop and parity-error counters.
//
// Optional feature:
//   `define OUT_MAPPER_PAYLOAD_EN
//     Each entry also stores the payload and the payload flag. A payload
//     packet is then emitted as two AER words: the key, then the payload.
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   cfg_key_mask     key filter mask (0 passes all keys)
//   cfg_key_value    key filter match value
//   cnt_clr          single-cycle clear of both counters
//   opkt_data        packet: [7:6] type, [1] payload flag, [0] parity,
//                    [39:8] key, [71:40] payload
//   opkt_vld/rdy     packet handshake (rdy = ~full, forced 0 in reset)
//   oaer_data        AER word, 0 while oaer_vld = 0
//   oaer_vld/rdy     AER handshake
//   parity_err       one-cycle pulse per parity-failed multicast packet
//   parity_err_cnt   saturating parity-error count
//   drop_cnt         saturating count of non-multicast and filtered packets

module spinn_aer_out_mapper #(
    parameter int AER_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          cfg_key_mask,
    input  logic [31:0]          cfg_key_value,
    input  logic                 cnt_clr,
    input  logic [71:0]          opkt_data,
    input  logic                 opkt_vld,
    output logic                 opkt_rdy,
    output logic [AER_WIDTH-1:0] oaer_data,
    output logic                 oaer_vld,
    input  logic                 oaer_rdy,
    output logic                 parity_err,
    output logic [CNT_WIDTH-1:0] parity_err_cnt,
    output logic [CNT_WIDTH-1:0] drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
`ifdef OUT_MAPPER_PAYLOAD_EN
    localparam int EW = 65;   // {payload flag, payload, key}
`else
    localparam int EW = 32;   // key only
`endif

    typedef enum logic {ST_KEY, ST_PLD} state_t;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [EW-1:0]        r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]        r_count;
    state_t               r_state, w_state_nxt;
    logic                 r_parity_err;
    logic [CNT_WIDTH-1:0] r_pe_cnt, r_drop_cnt;

    logic        w_full, w_empty, w_acc;
    logic        w_is_mc, w_par_ok, w_key_ok, w_push, w_drop, w_perr;
    logic [EW-1:0] w_entry, w_head;
    logic [31:0] w_head_key, w_head_pld;
    logic        w_head_has_pld;
    logic        w_vld, w_pop;
    logic [31:0] w_word;

    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign opkt_rdy = ~rst & ~w_full;
    assign w_acc    = opkt_vld & opkt_rdy;

    // Classification of the packet on the input port.
    assign w_is_mc  = (opkt_data[7:6] == 2'b00);
    assign w_par_ok = opkt_data[1] ? (^opkt_data[71:0]) : (^opkt_data[39:0]);
    assign w_key_ok = ((opkt_data[39:8] & cfg_key_mask) == (cfg_key_value & cfg_key_mask));
    assign w_push   = w_acc & w_is_mc & w_par_ok & w_key_ok;
    assign w_perr   = w_acc & w_is_mc & ~w_par_ok;
    assign w_drop   = w_acc & (~w_is_mc | (w_par_ok & ~w_key_ok));

`ifdef OUT_MAPPER_PAYLOAD_EN
    assign w_entry        = {opkt_data[1], opkt_data[71:40], opkt_data[39:8]};
    assign w_head         = r_mem[r_rd_ptr];
    assign w_head_key     = w_head[31:0];
    assign w_head_pld     = w_head[63:32];
    assign w_head_has_pld = w_head[64];
`else
    assign w_entry        = opkt_data[39:8];
    assign w_head         = r_mem[r_rd_ptr];
    assign w_head_key     = w_head;
    assign w_head_pld     = 32'd0;
    assign w_head_has_pld = 1'b0;
`endif

    // Storage holds data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            // Push and pop together leave the occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
            r_pe_cnt     <= '0;
            r_drop_cnt   <= '0;
        end else begin
            r_parity_err <= w_perr;
            if (cnt_clr) begin
                r_pe_cnt   <= '0;
                r_drop_cnt <= '0;
            end else begin
                if (w_perr) r_pe_cnt   <= sat_inc(r_pe_cnt);
                if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    // Output FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_KEY;
        else     r_state <= w_state_nxt;
    end

    // Output FSM: next state.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_KEY: if (~w_empty & oaer_rdy & w_head_has_pld) w_state_nxt = ST_PLD;
            ST_PLD: if (oaer_rdy) w_state_nxt = ST_KEY;
            default: w_state_nxt = ST_KEY;
        endcase
    end

    // Output FSM: outputs. The head entry stays in the FIFO until its last word is taken.
    always_comb begin
        w_vld  = 1'b0;
        w_word = 32'd0;
        w_pop  = 1'b0;
        case (r_state)
            ST_KEY: begin
                w_vld  = ~w_empty;
                w_word = w_head_key;
                w_pop  = ~w_empty & oaer_rdy & ~w_head_has_pld;
            end
            ST_PLD: begin
                w_vld  = 1'b1;
                w_word = w_head_pld;
                w_pop  = oaer_rdy;
            end
            default: ;
        endcase
    end

    assign oaer_vld       = w_vld;
    assign oaer_data      = w_vld ? w_word[AER_WIDTH-1:0] : '0;
    assign parity_err     = r_parity_err;
    assign parity_err_cnt = r_pe_cnt;
    assign drop_cnt       = r_drop_cnt;

endmodule

// File: tb/tb_spinn_aer_out_mapper.sv
// Directed testbench for spinn_aer_out_mapper (FIFO_DEPTH=4, AER_WIDTH=32, CNT_WIDTH=16).
module tb_spinn_aer_out_mapper;

    logic        clk;
    logic        rst;
    logic [31:0] cfg_key_mask, cfg_key_value;
    logic        cnt_clr;
    logic [71:0] opkt_data;
    logic        opkt_vld, opkt_rdy;
    logic [31:0] oaer_data;
    logic        oaer_vld, oaer_rdy;
    logic        parity_err;
    logic [15:0] parity_err_cnt, drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    spinn_aer_out_mapper #(.AER_WIDTH(32), .FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_key_mask(cfg_key_mask), .cfg_key_value(cfg_key_value),
        .cnt_clr(cnt_clr),
        .opkt_data(opkt_data), .opkt_vld(opkt_vld), .opkt_rdy(opkt_rdy),
        .oaer_data(oaer_data), .oaer_vld(oaer_vld), .oaer_rdy(oaer_rdy),
        .parity_err(parity_err), .parity_err_cnt(parity_err_cnt), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Builds a packet; parity bit chosen so the covered XOR is 1 (or 0 when bad=1).
    function automatic logic [71:0] mkpkt(input logic [1:0] typ, input logic [31:0] key,
                                          input logic [31:0] pld, input logic pf, input logic bad);
        logic [71:0] p;
        logic        par;
        p   = {pld, key, typ, 4'b0000, pf, 1'b0};
        par = pf ? (^p[71:0]) : (^p[39:0]);
        p[0] = ~par ^ bad;
        return p;
    endfunction

    task automatic send(input logic [71:0] pkt);
        opkt_data = pkt;
        opkt_vld  = 1'b1;
        step();
        opkt_vld  = 1'b0;
    endtask

    logic [31:0] exp_keys [4];

    initial begin
        rst = 1'b1; cfg_key_mask = '0; cfg_key_value = '0; cnt_clr = 1'b0;
        opkt_data = '0; opkt_vld = 1'b0; oaer_rdy = 1'b0;
        repeat (3) step();
        chk("rdy_in_reset", opkt_rdy, 1'b0);
        rst = 1'b0;
        step();
        chk("rst_vld", oaer_vld, 1'b0);
        chk("rst_data", oaer_data, 32'h0);
        chk("rst_perr", parity_err, 1'b0);
        chk("rst_pecnt", parity_err_cnt, 16'h0);
        chk("rst_drop", drop_cnt, 16'h0);
        chk("rst_rdy_after", opkt_rdy, 1'b1);

        // Single multicast packet, one-cycle latency
        oaer_rdy = 1'b1;
        send(mkpkt(2'b00, 32'h12345678, 32'h0, 1'b0, 1'b0));
        chk("mc_vld", oaer_vld, 1'b1);
        chk("mc_data", oaer_data, 32'h12345678);
        step();
        chk("mc_vld_after_pop", oaer_vld, 1'b0);
        chk("mc_drop", drop_cnt, 16'h0);
        chk("mc_pecnt", parity_err_cnt, 16'h0);

        // Fill to full while the sink stalls
        oaer_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            opkt_data = mkpkt(2'b00, 32'hA0 + i, 32'h0, 1'b0, 1'b0);
            opkt_vld  = 1'b1;
            step();
        end
        opkt_vld = 1'b0;
        chk("full_rdy", opkt_rdy, 1'b0);
        chk("full_head", oaer_data, 32'hA0);
        step();
        chk("stall_hold_vld", oaer_vld, 1'b1);
        chk("stall_hold_data", oaer_data, 32'hA0);

        oaer_rdy = 1'b1;
        step();
        chk("pop_a0_next", oaer_data, 32'hA1);
        chk("pop_rdy", opkt_rdy, 1'b1);
        // push A4 and pop A1 together at count 3
        send(mkpkt(2'b00, 32'hA4, 32'h0, 1'b0, 1'b0));
        oaer_rdy = 1'b0;
        chk("pushpop_head", oaer_data, 32'hA2);
        chk("pushpop_rdy", opkt_rdy, 1'b1);
        // one more push must fill it exactly (count was 3)
        send(mkpkt(2'b00, 32'hA5, 32'h0, 1'b0, 1'b0));
        chk("refill_rdy", opkt_rdy, 1'b0);
        exp_keys[0] = 32'hA2; exp_keys[1] = 32'hA3; exp_keys[2] = 32'hA4; exp_keys[3] = 32'hA5;
        oaer_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_vld", oaer_vld, 1'b1);
            chk("drain_data", oaer_data, exp_keys[i]);
            step();
        end
        chk("drain_empty", oaer_vld, 1'b0);

        // Parity failure
        send(mkpkt(2'b00, 32'h55, 32'h0, 1'b0, 1'b1));
        chk("perr_pulse", parity_err, 1'b1);
        chk("perr_cnt", parity_err_cnt, 16'h1);
        chk("perr_no_out", oaer_vld, 1'b0);
        step();
        chk("perr_pulse_end", parity_err, 1'b0);
        chk("perr_cnt_hold", parity_err_cnt, 16'h1);

        // Non-multicast packet
        send(mkpkt(2'b01, 32'h66, 32'h0, 1'b0, 1'b0));
        chk("nmc_drop", drop_cnt, 16'h1);
        chk("nmc_no_out", oaer_vld, 1'b0);
        chk("nmc_no_perr", parity_err, 1'b0);

        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("clr_drop", drop_cnt, 16'h0);
        chk("clr_pecnt", parity_err_cnt, 16'h0);

        // Key filter
        cfg_key_mask = 32'hFF000000; cfg_key_value = 32'hAB000000;
        send(mkpkt(2'b00, 32'hAB000001, 32'h0, 1'b0, 1'b0));
        chk("filt_pass_vld", oaer_vld, 1'b1);
        chk("filt_pass_data", oaer_data, 32'hAB000001);
        send(mkpkt(2'b00, 32'hCD000001, 32'h0, 1'b0, 1'b0));
        chk("filt_drop_no_out", oaer_vld, 1'b0);
        chk("filt_drop_cnt", drop_cnt, 16'h1);
        cfg_key_mask = '0; cfg_key_value = '0;

        // Payload packet with stalls
        oaer_rdy = 1'b0;
        send(mkpkt(2'b00, 32'h1, 32'hDEADBEEF, 1'b1, 1'b0));
        chk("pld_key", oaer_data, 32'h1);
        step();
        chk("pld_key_hold", oaer_data, 32'h1);
        oaer_rdy = 1'b1;
        step();
`ifdef OUT_MAPPER_PAYLOAD_EN
        chk("pld_word_vld", oaer_vld, 1'b1);
        chk("pld_word", oaer_data, 32'hDEADBEEF);
        oaer_rdy = 1'b0;
        step();
        chk("pld_word_hold", oaer_data, 32'hDEADBEEF);
        oaer_rdy = 1'b1;
        step();
        chk("pld_done", oaer_vld, 1'b0);
`else
        chk("pld_key_only", oaer_vld, 1'b0);
`endif

        // Reset with buffered entries (in PLD state when payloads are enabled)
        oaer_rdy = 1'b0;
        send(mkpkt(2'b00, 32'h2, 32'hCAFEF00D, 1'b1, 1'b0));
        send(mkpkt(2'b00, 32'h3, 32'h0, 1'b0, 1'b0));
        oaer_rdy = 1'b1;
        step();
        oaer_rdy = 1'b0;
        rst = 1'b1;
        step();
        chk("rst_mid_vld", oaer_vld, 1'b0);
        chk("rst_mid_rdy", opkt_rdy, 1'b0);
        rst = 1'b0;
        step();
        chk("rst_mid_empty", oaer_vld, 1'b0);
        chk("rst_mid_rdy_after", opkt_rdy, 1'b1);

        // Saturation of drop_cnt
        opkt_data = mkpkt(2'b01, 32'h77, 32'h0, 1'b0, 1'b0);
        opkt_vld  = 1'b1;
        repeat (65535) step();
        opkt_vld  = 1'b0;
        chk("sat_reach", drop_cnt, 16'hFFFF);
        send(mkpkt(2'b10, 32'h78, 32'h0, 1'b0, 1'b0));
        chk("sat_hold", drop_cnt, 16'hFFFF);
        chk("sat_pecnt", parity_err_cnt, 16'h0);
        cnt_clr = 1'b1;
        send(mkpkt(2'b01, 32'h79, 32'h0, 1'b0, 1'b0));
        cnt_clr = 1'b0;
        chk("clr_priority", drop_cnt, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
